// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the data-side store buffer.
// Holds the FIFO entry layout, the drain FSM encoding, the pointer-width
// helper and the word-address boundary used for load forwarding.
package store_buffer_pkg;

  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int WORD_LSB = 2;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/store_fwd_match.sv
// Youngest-first forwarding matcher: scans the valid entries from oldest
// (head) to youngest so that the last word-address match found wins.
module store_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  parameter int PW    = clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     head,
  input  logic [AW-1:0]     ALUResult,
  output logic              hit,
  output logic [DW-1:0]     data
);

  // Byte-offset bits play no part in matching; gather them so they are
  // visibly consumed.
  logic unused_byte_bits;

  // Priority scan, oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] &&
          (entries[idx].addr[AW-1:WORD_LSB] == ALUResult[AW-1:WORD_LSB])) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

  // Fold the ignored low address bits together.
  always_comb begin
    unused_byte_bits = ^ALUResult[WORD_LSB-1:0];
    for (int i = 0; i < DEPTH; i++) begin
      unused_byte_bits = unused_byte_bits ^ (^entries[i].addr[WORD_LSB-1:0]);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Data-side store buffer: accepts one core store per cycle into a circular
// FIFO, drains entries in order over a registered req/ack bus and forwards
// buffered data to loads so ReadData stays coherent.
// Optional feature macro: STORE_COALESCE_EN -- a store to the same word as
// the youngest entry (unless that entry is the head being drained) updates
// it in place instead of allocating.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [AW-1:0] ALUResult,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] ReadData,
  output logic          full,
  output logic          overflow,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack
);

  localparam int            PW      = clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);

  sb_entry_t     entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  drain_state_t  state;
  drain_state_t  state_next;

  logic             push;
  logic             pop;
  logic             drop;
  logic             coalesce;
  logic [DEPTH-1:0] valid;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

`ifdef STORE_COALESCE_EN
  logic [PW-1:0] youngest;
  assign youngest = tail - PW'(1);
  // The head under drain is never rewritten, since the bus may be latching it.
  assign coalesce = MemWrite && (count != '0) &&
                    (entries[youngest].addr[AW-1:WORD_LSB] == ALUResult[AW-1:WORD_LSB]) &&
                    !((state == REQ) && (youngest == head));
`else
  assign coalesce = 1'b0;
`endif

  // Acceptance uses the occupancy at the start of the cycle, so a slot freed
  // by a same-cycle pop cannot be reused.
  assign push       = MemWrite && !coalesce && (count < DEPTH_C);
  assign drop       = MemWrite && !coalesce && !push;
  assign pop        = (state == REQ) && mem_ack;
  assign count_next = count + (PW + 1)'(push) - (PW + 1)'(pop);

  assign full      = (count == DEPTH_C);
  assign mem_raddr = ALUResult;
  assign mem_addr  = entries[head].addr;
  assign mem_wdata = entries[head].data;

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count_next;
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage writes: allocate at tail or update the youngest in place.
  always_ff @(posedge clk) begin
    // NOTE: entry contents are left unreset; occupancy alone decides validity,
    // which keeps the storage a plain register file.
    if (push) begin
      entries[tail] <= '{addr: ALUResult, data: WriteData};
    end
`ifdef STORE_COALESCE_EN
    else if (coalesce) begin
      entries[youngest].data <= WriteData;
    end
`endif
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Drain FSM next state: request whenever anything remains after this edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_next != '0) state_next = REQ;
      REQ:     if (pop && (count_next == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drain FSM outputs.
  always_comb begin
    mem_req = (state == REQ);
  end

  // Per-slot valid mask derived from head and occupancy.
  always_comb begin
    logic [PW-1:0] off;
    valid = '0;
    off   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off      = PW'(j) - head;
      valid[j] = ({1'b0, off} < count);
    end
  end

  store_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .PW    (PW)
  ) u_fwd (
    .entries   (entries),
    .valid     (valid),
    .head      (head),
    .ALUResult (ALUResult),
    .hit       (fwd_hit),
    .data      (fwd_data)
  );

  // Load data: youngest buffered match, else memory.
  always_comb begin
    ReadData = fwd_hit ? fwd_data : mem_rdata;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Data-side store buffer between the single-cycle core's memory outputs and a handshaked data-memory bus.
- Accepts core stores at one per cycle into a FIFO. Drains them to memory in order with a req/ack handshake.
- Forwards buffered store data to loads, so the core's combinational ReadData stays coherent.
- Asserts full so the top level can stall the core.

Parameters:
- DEPTH, 4, number of store entries; power of two, ≥2
- AW, 32, address width (core ALUResult)
- DW, 32, data width (core WriteData/ReadData)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- MemWrite  in  1  core store strobe, one store per cycle
- ALUResult  in  AW  core load/store byte address
- WriteData  in  DW  core store data
- ReadData  out  DW  load data to core; forwarded entry or mem_rdata
- full  out  1  buffer holds DEPTH entries; core must stall stores
- overflow  out  1  sticky: a store arrived while full and was dropped
- mem_raddr  out  AW  combinational load address to memory; equals ALUResult
- mem_rdata  in  DW  combinational memory read data for mem_raddr
- mem_req  out  1  drain request; registered
- mem_addr  out  AW  head-entry address, stable while mem_req=1
- mem_wdata  out  DW  head-entry data, stable while mem_req=1
- mem_ack  in  1  memory accepted the head entry this cycle

Behaviour:
- Storage:
  - Circular FIFO of DEPTH entries {addr, data}.
  - head/tail pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Reset: head=tail=count=0, mem_req=0, overflow=0, full=0, FSM=IDLE. Entry contents are don't-care.
- Reset mid-drain: mem_req drops the next cycle. All entries are discarded. An ack in the reset cycle is ignored.
- Push:
  - A store is accepted when MemWrite=1 and count<DEPTH, using count sampled at the start of the cycle.
  - No same-cycle bypass of a freed slot: when full, a store is dropped even if mem_ack pops in the same cycle.
- Dropped store: sets overflow (sticky until reset); the buffer is otherwise unchanged.
- Pop: happens on any edge where mem_req=1 and mem_ack=1. Simultaneous push and pop leaves count unchanged, with both pointers advancing.
- full = (count==DEPTH), combinational from registers.
- Drain FSM:
  - IDLE: mem_req=0. Go to REQ when count>0 at the edge, counting a same-cycle push. A store accepted in cycle N gives mem_req=1 in cycle N+1.
  - REQ: mem_req=1; mem_addr/mem_wdata come from the head entry. Hold until mem_ack.
  - On ack in REQ: pop. Stay in REQ if the remaining count (including any same-cycle push) is >0, otherwise go to IDLE. Back-to-back acks drain one entry per cycle.
  - mem_ack while in IDLE is ignored.
- Forwarding (combinational):
  - Compare ALUResult[AW-1:2] with every valid entry's addr[AW-1:2].
  - If any entry matches, ReadData takes the youngest matching entry's data. Otherwise ReadData=mem_rdata.
  - The head entry currently in REQ still forwards until its popping edge.
  - A store in the current cycle does not forward to itself.
- Addresses are word-granular; addr[1:0] is stored but ignored for matching. Full-word stores only.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined:
  - A store whose word address matches the youngest valid entry overwrites that entry's data in place. count is unchanged and the store is accepted even when full.
  - This does not apply when the youngest entry is the head in REQ; in that case a new entry is allocated normally.
- Undefined: every store allocates a new entry, and matching is used only for forwarding.

Decomposition:
- Shared package holds:
  - the entry struct typedef {addr, data}
  - the FSM state enum {IDLE, REQ}
  - the pointer-width function clog2(DEPTH)
  - the constant WORD_LSB=2
- One natural sub-module, store_fwd_match: a combinational youngest-first priority matcher over the entries. Inputs: entries, valid mask, head pointer, ALUResult. Outputs: hit and data.

Test Plan:
- Single store, no ack: store 0x100/0xDEADBEEF, then hold mem_ack=0 → from N+1, mem_req=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, all held stable. A load of 0x100 returns 0xDEADBEEF while mem_rdata=0.
- Fill and overflow: 4 stores with mem_ack=0 → full=1; a 5th store leaves count=4 and sets overflow=1. An ack then gives full=0 next cycle while overflow stays 1.
- Ordered drain: stores to 0x0/0x4/0x8/0xC, then mem_ack=1 continuously → four consecutive accepted beats in order, then mem_req=0.
- Youngest-first forwarding: store 0x20←1, then 0x20←2 (coalescing off) → a load of 0x22 returns 2. After both pops, the load returns mem_rdata.
- Push at full with ack: full, with MemWrite=1 and mem_ack=1 in the same cycle → store dropped, overflow=1, count=3.
- Reset mid-drain: count=3, mem_req=1, reset pulsed for one cycle → next cycle mem_req=0, count=0, full=0, overflow=0.
- With STORE_COALESCE_EN: store 0x40←A, 0x44←B, 0x44←C with no ack → count=2; the second entry holds C; the drain shows 0x40/A then 0x44/C.
